// File: rtl/a_rf_operand_sequencer.sv
// a_rf_operand_sequencer: shift-loaded operand register file with cascade tap and autonomous multiplier-operand sequencer
module a_rf_operand_sequencer #(
    parameter int DATA_W = 30,
    parameter int MULT_W = 27,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   ACIN,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                clear,
    input  logic                INMODEA,
    input  logic                seq_start,
    input  logic                seq_stop,
    input  logic [AW:0]         seq_len,
    output logic                seq_busy,
    output logic                seq_err,
    output logic [AW:0]         fill_level,
    input  logic [AW-1:0]       ACOUT_addr,
    output logic [DATA_W-1:0]   ACOUT,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   X_MUX,
    output logic [2*MULT_W-1:0] A_MULT,
    input  logic                configuration_input,
    input  logic                configuration_enable,
    output logic                configuration_output
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t state, state_n;
    logic [DATA_W-1:0] rf [DEPTH];
    logic a_input, dual, rpt;
    logic [AW:0] ptr, ptr_n, ptr_step;
    logic [AW-1:0] pa, pb;
    logic issue, err_n, start_ok, load;

    assign seq_busy = state == RUN;
    assign load_ready = !seq_busy;
    assign load = load_valid && load_ready && !clear;
    assign configuration_output = rpt;
    assign ACOUT = rf[ACOUT_addr];
    assign pa = ptr[AW-1:0];
    assign pb = pa + AW'(1);
    assign ptr_step = ptr + (dual ? (AW+1)'(2) : (AW+1)'(1));
    assign start_ok = seq_len != '0 && seq_len <= fill_level && !(dual && seq_len[0]);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            fill_level <= '0;
            {a_input, dual, rpt} <= '0;
        end else begin
            if (clear && !seq_busy) begin
                for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
                fill_level <= '0;
            end else if (load) begin
                rf[0] <= a_input ? ACIN : A;
                for (int i = 1; i < DEPTH; i++) rf[i] <= rf[i-1];
                fill_level <= fill_level == FULL ? FULL : fill_level + 1'b1;
            end
            if (configuration_enable && !seq_busy) {a_input, dual, rpt} <= {configuration_input, a_input, dual};
        end
    end

    always_comb begin
        state_n = state;
        ptr_n = ptr;
        issue = 1'b0;
        err_n = 1'b0;
        if (state == IDLE) begin
            if (seq_start) begin
                state_n = start_ok ? RUN : IDLE;
                ptr_n = start_ok ? '0 : ptr;
                err_n = !start_ok;
            end
        end else if (seq_stop) begin
            state_n = IDLE;
        end else if (!out_valid || out_ready) begin
            issue = 1'b1;
            ptr_n = ptr_step >= seq_len ? '0 : ptr_step;
            state_n = ptr_step >= seq_len && !rpt ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr <= '0;
            seq_err <= 1'b0;
            out_valid <= 1'b0;
            X_MUX <= '0;
            A_MULT <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            seq_err <= err_n;
            out_valid <= issue || (out_valid && !out_ready);
            if (issue) begin
                X_MUX <= rf[pa];
                A_MULT <= {dual ? rf[pb][MULT_W-1:0] : {MULT_W{1'b0}}, rf[pa][MULT_W-1:0] & {MULT_W{INMODEA}}};
            end
        end
    end
endmodule

// File: tb/tb_a_rf_operand_sequencer.sv
// tb_a_rf_operand_sequencer: table-driven load/cascade vectors plus directed sequencer scenarios
module tb_a_rf_operand_sequencer;
    localparam int DW = 30, MW = 27, D = 8, AW = 3;
    logic clk = 1'b0, RST;
    logic [DW-1:0] A, ACIN, ACOUT, X_MUX;
    logic load_valid, load_ready, clear, INMODEA, seq_start, seq_stop, seq_busy, seq_err;
    logic [AW:0] seq_len, fill_level;
    logic [AW-1:0] ACOUT_addr;
    logic out_valid, out_ready;
    logic [2*MW-1:0] A_MULT;
    logic configuration_input, configuration_enable, configuration_output;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic clr;
        logic lv;
        logic [DW-1:0] a;
        logic [AW-1:0] addr;
        logic [AW:0] fill;
        logic [DW-1:0] acout;
    } vec_t;
    vec_t tbl [11];

    a_rf_operand_sequencer #(.DATA_W(DW), .MULT_W(MW), .DEPTH(D)) dut (
        .clk(clk), .RST(RST), .A(A), .ACIN(ACIN), .load_valid(load_valid), .load_ready(load_ready),
        .clear(clear), .INMODEA(INMODEA), .seq_start(seq_start), .seq_stop(seq_stop), .seq_len(seq_len),
        .seq_busy(seq_busy), .seq_err(seq_err), .fill_level(fill_level), .ACOUT_addr(ACOUT_addr),
        .ACOUT(ACOUT), .out_valid(out_valid), .out_ready(out_ready), .X_MUX(X_MUX), .A_MULT(A_MULT),
        .configuration_input(configuration_input), .configuration_enable(configuration_enable),
        .configuration_output(configuration_output)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic ai, input logic d, input logic r);
        configuration_enable = 1'b1;
        configuration_input = r;
        tick();
        configuration_input = d;
        tick();
        configuration_input = ai;
        tick();
        configuration_enable = 1'b0;
    endtask

    task automatic start(input logic [AW:0] len);
        seq_len = len;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic load1(input logic [DW-1:0] v);
        A = v;
        ACIN = v + 30'h100;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic out_chk(input string nm, input logic [DW-1:0] x, input logic [MW-1:0] hi, input logic [MW-1:0] lo);
        chk({nm, " valid"}, 64'(out_valid), 64'(1));
        chk({nm, " X_MUX"}, 64'(X_MUX), 64'(x));
        chk({nm, " A_MULT"}, 64'(A_MULT), 64'({hi, lo}));
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 30'h11, 3'd0, 4'd1, 30'h11};
        tbl[1]  = '{1'b0, 1'b1, 30'h22, 3'd1, 4'd2, 30'h11};
        tbl[2]  = '{1'b0, 1'b1, 30'h33, 3'd0, 4'd3, 30'h33};
        tbl[3]  = '{1'b0, 1'b0, 30'h00, 3'd1, 4'd3, 30'h22};
        tbl[4]  = '{1'b0, 1'b0, 30'h00, 3'd2, 4'd3, 30'h11};
        tbl[5]  = '{1'b1, 1'b1, 30'h44, 3'd0, 4'd0, 30'h00};
        tbl[6]  = '{1'b0, 1'b1, 30'h3FFFFFFF, 3'd0, 4'd1, 30'h3FFFFFFF};
        tbl[7]  = '{1'b1, 1'b0, 30'h00, 3'd0, 4'd0, 30'h00};
        tbl[8]  = '{1'b0, 1'b1, 30'h11, 3'd0, 4'd1, 30'h11};
        tbl[9]  = '{1'b0, 1'b1, 30'h22, 3'd0, 4'd2, 30'h22};
        tbl[10] = '{1'b0, 1'b1, 30'h33, 3'd2, 4'd3, 30'h11};
        RST = 1'b1;
        {A, ACIN, load_valid, clear, seq_start, seq_stop, seq_len, ACOUT_addr} = '0;
        {configuration_input, configuration_enable} = '0;
        INMODEA = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rst fill", 64'(fill_level), 64'(0));
        chk("rst valid", 64'(out_valid), 64'(0));
        chk("rst busy", 64'(seq_busy), 64'(0));
        chk("rst err", 64'(seq_err), 64'(0));
        chk("rst xmux", 64'(X_MUX), 64'(0));
        chk("rst amult", 64'(A_MULT), 64'(0));
        chk("rst cfgout", 64'(configuration_output), 64'(0));
        chk("rst load_ready", 64'(load_ready), 64'(1));
        RST = 1'b0;
        tick();
        for (int i = 0; i < 11; i++) begin
            clear = tbl[i].clr;
            load_valid = tbl[i].lv;
            A = tbl[i].a;
            ACOUT_addr = tbl[i].addr;
            tick();
            chk($sformatf("vec%0d fill", i), 64'(fill_level), 64'(tbl[i].fill));
            chk($sformatf("vec%0d acout", i), 64'(ACOUT), 64'(tbl[i].acout));
        end
        clear = 1'b0;
        load_valid = 1'b0;
        start(4'd3);
        chk("single busy", 64'(seq_busy), 64'(1));
        chk("single first latency", 64'(out_valid), 64'(0));
        chk("single load_ready", 64'(load_ready), 64'(0));
        tick();
        out_chk("single0", 30'h33, 27'h0, 27'h33);
        tick();
        out_chk("single1", 30'h22, 27'h0, 27'h22);
        tick();
        out_chk("single2", 30'h11, 27'h0, 27'h11);
        chk("single end busy", 64'(seq_busy), 64'(1'b0));
        chk("single end load_ready", 64'(load_ready), 64'(1));
        tick();
        chk("single drain", 64'(out_valid), 64'(0));
        start(4'd3);
        tick();
        out_chk("bp0", 30'h33, 27'h0, 27'h33);
        out_ready = 1'b0;
        tick();
        out_chk("bp hold1", 30'h33, 27'h0, 27'h33);
        tick();
        out_chk("bp hold2", 30'h33, 27'h0, 27'h33);
        chk("bp busy", 64'(seq_busy), 64'(1));
        out_ready = 1'b1;
        tick();
        out_chk("bp1", 30'h22, 27'h0, 27'h22);
        tick();
        out_chk("bp2", 30'h11, 27'h0, 27'h11);
        chk("bp end busy", 64'(seq_busy), 64'(0));
        tick();
        chk("bp drain", 64'(out_valid), 64'(0));
        load1(30'h44);
        chk("dual fill", 64'(fill_level), 64'(4));
        cfg(1'b0, 1'b1, 1'b1);
        chk("cfg out", 64'(configuration_output), 64'(1));
        start(4'd4);
        tick();
        out_chk("dual0", 30'h44, 27'h33, 27'h44);
        tick();
        out_chk("dual1", 30'h22, 27'h11, 27'h22);
        tick();
        out_chk("dual repeat", 30'h44, 27'h33, 27'h44);
        INMODEA = 1'b0;
        tick();
        out_chk("dual inmodea", 30'h22, 27'h11, 27'h0);
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        INMODEA = 1'b1;
        chk("stop busy", 64'(seq_busy), 64'(0));
        chk("stop valid", 64'(out_valid), 64'(0));
        chk("stop xmux hold", 64'(X_MUX), 64'(30'h22));
        start(4'd3);
        chk("rej odd err", 64'(seq_err), 64'(1));
        chk("rej odd busy", 64'(seq_busy), 64'(0));
        tick();
        chk("rej pulse", 64'(seq_err), 64'(0));
        cfg(1'b0, 1'b0, 1'b0);
        start(4'd5);
        chk("rej long err", 64'(seq_err), 64'(1));
        chk("rej long busy", 64'(seq_busy), 64'(0));
        start(4'd0);
        chk("rej zero err", 64'(seq_err), 64'(1));
        start(4'd4);
        chk("accept full err", 64'(seq_err), 64'(0));
        chk("accept full busy", 64'(seq_busy), 64'(1));
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        chk("stop early busy", 64'(seq_busy), 64'(0));
        chk("stop early valid", 64'(out_valid), 64'(0));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear fill", 64'(fill_level), 64'(0));
        cfg(1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 9; v++) load1(30'(v));
        chk("ovf fill", 64'(fill_level), 64'(8));
        ACOUT_addr = 3'd0;
        #1;
        chk("ovf newest", 64'(ACOUT), 64'(30'h109));
        ACOUT_addr = 3'd7;
        #1;
        chk("ovf oldest", 64'(ACOUT), 64'(30'h102));
        start(4'd8);
        configuration_enable = 1'b1;
        configuration_input = 1'b1;
        tick();
        tick();
        tick();
        configuration_enable = 1'b0;
        configuration_input = 1'b0;
        chk("cfg ignored busy", 64'(configuration_output), 64'(0));
        out_chk("run3", 30'h107, 27'h0, 27'h107);
        #2;
        RST = 1'b1;
        #1;
        chk("mid rst xmux", 64'(X_MUX), 64'(0));
        chk("mid rst amult", 64'(A_MULT), 64'(0));
        chk("mid rst valid", 64'(out_valid), 64'(0));
        chk("mid rst busy", 64'(seq_busy), 64'(0));
        chk("mid rst fill", 64'(fill_level), 64'(0));
        chk("mid rst acout", 64'(ACOUT), 64'(0));
        chk("mid rst cfgout", 64'(configuration_output), 64'(0));
        RST = 1'b0;
        tick();
        chk("post rst load_ready", 64'(load_ready), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
